// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// univ_shift_reg : parametrised universal shift register, tri-state output,
// auto-shift burst engine.                                       Rev 1.0
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             oe,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output tri   [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_reg,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bmode, w_bmode_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] m,
                                            input logic [WIDTH-1:0] v,
                                            input logic [WIDTH-1:0] ld,
                                            input logic si_r,
                                            input logic si_l);
    case (m)
      3'd1:    f_op = ld;
      3'd2:    f_op = {si_r, v[WIDTH-1:1]};
      3'd3:    f_op = {v[WIDTH-2:0], si_l};
      3'd4:    f_op = {v[0], v[WIDTH-1:1]};
      3'd5:    f_op = {v[WIDTH-2:0], v[WIDTH-1]};
      3'd6:    f_op = '0;
      3'd7:    f_op = v + c_Q_ONE;
      default: f_op = v;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && en && start &&
                    (mode >= 3'd2) && (mode <= 3'd5) && (len != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_bmode_nxt = r_bmode;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;   // done is a single-cycle pulse, cleared even when en=0
    if (en) begin
      if (r_state == S_IDLE) begin
        w_q_nxt = f_op(mode, r_q, d, sr_in, sl_in);
        if (w_accept) begin
          w_bmode_nxt = mode;
          w_cnt_nxt   = len - c_CNT_ONE;
          if (len == c_CNT_ONE) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_busy_nxt  = 1'b1;
          end
        end
      end else begin
        w_q_nxt   = f_op(r_bmode, r_q, d, sr_in, sl_in);
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_bmode <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bmode <= w_bmode_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q      = oe ? {WIDTH{1'bz}} : r_q;
  assign q_reg  = r_q;
  assign sr_out = r_q[0];
  assign sl_out = r_q[WIDTH-1];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// Directed testbench for univ_shift_reg (WIDTH=4, CNT_W=3).
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       clr, en, oe, sr_in, sl_in, start;
  logic [2:0] mode, len;
  logic [3:0] d;
  wire  [3:0] q;
  logic [3:0] q_reg;
  logic       sr_out, sl_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .en(en), .oe(oe), .mode(mode), .d(d),
    .sr_in(sr_in), .sl_in(sl_in), .start(start), .len(len),
    .q(q), .q_reg(q_reg), .sr_out(sr_out), .sl_out(sl_out),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
    check({tag, "_q"}, q_reg, eq);
    check({tag, "_busy"}, {3'b0, busy}, {3'b0, eb});
    check({tag, "_done"}, {3'b0, done}, {3'b0, ed});
  endtask

  task automatic load(input logic [3:0] v);
    mode = 3'd1; d = v; start = 1'b0; step();
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; oe = 1'b0; sr_in = 1'b0; sl_in = 1'b0;
    start = 1'b0; mode = 3'd0; len = 3'd0; d = 4'd0;
    #2;
    chk_st("reset", 4'b0000, 1'b0, 1'b0);
    check("reset_qout", q, 4'b0000);

    @(negedge clk);
    clr = 1'b1; en = 1'b1;
    load(4'b0101);
    check("load_qreg", q_reg, 4'b0101);
    check("load_qout", q, 4'b0101);
    oe = 1'b1; #1;
    check("oe_hiz", {3'b0, (q !== q_reg)}, 4'd1);
    check("oe_keep", q_reg, 4'b0101);
    oe = 1'b0;

    mode = 3'd2; sr_in = 1'b1; step(); check("shr", q_reg, 4'b1010);
    check("sr_out", {3'b0, sr_out}, 4'd0);
    check("sl_out", {3'b0, sl_out}, 4'd1);
    mode = 3'd3; sl_in = 1'b0; step(); check("shl", q_reg, 4'b0100);
    mode = 3'd6; step(); check("clear", q_reg, 4'b0000);
    load(4'b1000); mode = 3'd5; step(); check("rotl", q_reg, 4'b0001);
    load(4'b1111); mode = 3'd7; step(); check("inc_wrap", q_reg, 4'b0000);
    mode = 3'd7; step(); check("inc", q_reg, 4'b0001);

    // en low with start high: nothing moves
    en = 1'b0; start = 1'b1; mode = 3'd4; len = 3'd3; step();
    chk_st("en_low", 4'b0001, 1'b0, 1'b0);

    // rotate-right burst of 3 with a mid-burst mode change and en stall
    en = 1'b1; step();
    chk_st("b1", 4'b1000, 1'b1, 1'b0);
    start = 1'b0; mode = 3'd1; d = 4'b1111; step();
    chk_st("b2", 4'b0100, 1'b1, 1'b0);
    en = 1'b0; step();
    chk_st("b_stall", 4'b0100, 1'b1, 1'b0);
    en = 1'b1; step();
    chk_st("b3", 4'b0010, 1'b0, 1'b1);
    mode = 3'd0; step();
    chk_st("b_after", 4'b0010, 1'b0, 1'b0);

    // reset mid-burst
    load(4'b0001);
    start = 1'b1; mode = 3'd4; len = 3'd5; step();
    chk_st("r1", 4'b1000, 1'b1, 1'b0);
    start = 1'b0; step();
    chk_st("r2", 4'b0100, 1'b1, 1'b0);
    #2 clr = 1'b0; #1;
    chk_st("r_async", 4'b0000, 1'b0, 1'b0);
    #1 clr = 1'b1;
    start = 1'b1; mode = 3'd1; d = 4'b1001; len = 3'd3; step();
    chk_st("r_load", 4'b1001, 1'b0, 1'b0);
    check("sr_out1", {3'b0, sr_out}, 4'd1);

    // len=0 start: plain shift
    mode = 3'd2; len = 3'd0; sr_in = 1'b1; step();
    chk_st("len0", 4'b1100, 1'b0, 1'b0);

    // len=1 burst: single shift, done with no busy
    mode = 3'd3; len = 3'd1; sl_in = 1'b1; step();
    chk_st("len1", 4'b1001, 1'b0, 1'b1);
    start = 1'b0; mode = 3'd0; en = 1'b0; step();
    chk_st("len1_clr", 4'b1001, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with tri-state output, the successor to our fixed 4-bit clear/output-enable register. It adds load, shift, rotate, clear and increment modes, serial inputs and outputs, and an auto-shift burst engine. Bursts shift or rotate a programmed number of positions, with `busy`/`done` handshaking. It sits on the datapath wherever a bus-attachable storage, serialiser or rotator stage is needed.

## Interface
- `WIDTH`, 4: register width in bits; must be ≥ 2.
- `CNT_W`, 3: width of the burst length field; bursts of 1..2^CNT_W−1 positions.

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset; one clock; reset is asynchronous and active-low.
- `en`  in  1  clock enable; when low, all state holds, including the burst FSM.
- `oe`  in  1  output enable, active-low; `oe`=1 drives `q` to high-Z.
- `mode`  in  3  operation select, sampled on each enabled edge.
- `d`  in  WIDTH  parallel load data.
- `sr_in`  in  1  serial input for shift-right; enters the MSB.
- `sl_in`  in  1  serial input for shift-left; enters the LSB.
- `start`  in  1  burst request.
- `len`  in  CNT_W  burst length in positions.
- `q`  out  WIDTH  tri-state copy of the register.
- `q_reg`  out  WIDTH  register contents, always driven.
- `sr_out`  out  1  `q_reg[0]`, combinational.
- `sl_out`  out  1  `q_reg[WIDTH-1]`, combinational.
- `busy`  out  1  burst in progress, registered.
- `done`  out  1  one-cycle pulse marking burst completion, registered.

## Operation
- Mode encoding, applied on an enabled edge while IDLE:
  - 0: hold.
  - 1: load `d`.
  - 2: shift right, `{sr_in, q[W-1:1]}`.
  - 3: shift left, `{q[W-2:0], sl_in}`.
  - 4: rotate right, `{q[0], q[W-1:1]}`.
  - 5: rotate left, `{q[W-2:0], q[W-1]}`.
  - 6: synchronous clear.
  - 7: increment, modulo 2^WIDTH (wrap from all-ones to 0).
- FSM states: IDLE and BUSY. A down-counter `cnt` of width CNT_W tracks remaining positions.
- Burst accept conditions, all on one edge:
  - FSM is IDLE.
  - `en`=1 and `start`=1.
  - `mode` is in 2..5.
  - `len` is nonzero.
- On the accepting edge:
  - The first shift is performed on that edge.
  - `mode` is latched as `bmode`.
  - `cnt` is set to `len`−1.
  - If `len`=1, the FSM stays IDLE and `done` pulses.
  - Otherwise the FSM goes to BUSY and `busy` is set to 1.
- A `start` that does not meet the accept conditions is ignored. With mode 0/1/6/7 or `len`=0, the edge executes the plain `mode` operation.
- BUSY behaviour:
  - Each enabled edge performs one `bmode` operation and decrements `cnt`.
  - The edge with `cnt`=1 performs the final shift, returns to IDLE, clears `busy` and sets `done`.
  - `mode`, `d` and `start` are ignored.
  - `sr_in` and `sl_in` are still sampled every shift.
- `done` is high for exactly one clock and cleared on the next edge regardless of `en`.
- Output enable:
  - `q` = `q_reg` when `oe`=0, and all-Z when `oe`=1.
  - `oe` is combinational and never affects stored state.

## Timing
- Reset (`clr`=0) asynchronously forces:
  - `q_reg`=0, `cnt`=0, `busy`=0, `done`=0, state IDLE.
  - `q` = 0 if `oe`=0, else Z.
- Reset is honoured mid-burst; the burst is abandoned with no `done` pulse.
- Release of `clr` is synchronised externally; the first enabled edge after release operates normally.
- `q_reg`, `busy` and `done` update on the rising edge only.
- `q`, `sr_out` and `sl_out` follow with combinational delay only.
- Burst latency: a burst of length L accepted at edge k finishes at enabled edge k+L−1 (counting enabled edges only).
  - `busy` is high from after edge k to after edge k+L−1.
  - `done` is high for the cycle after edge k+L−1.
- Back-to-back bursts: `start` is accepted on the edge right after the `done` cycle begins, since the FSM is already IDLE there.
- Simultaneous `en`=0 with `start`=1: no accept, no state change.

## Test plan
- Reset, then `mode`=1 with `d`=0101 → `q_reg`=0101 and `q`=0101. Set `oe`=1 → `q`=ZZZZ while `q_reg` stays 0101.
- From 0101:
  - `mode`=2 with `sr_in`=1 → 1010.
  - Then `mode`=3 with `sl_in`=0 → 0100.
  - Then `mode`=6 → 0000.
- From 1000, `mode`=5 → 0001. From 1111, `mode`=7 → 0000 (wrap).
- From `q_reg`=0001, `start`=1, `mode`=4, `len`=3:
  - Successive edges give 1000, 0100, 0010.
  - `busy` is high for 2 cycles, then `done` pulses for 1 cycle.
  - Changing `mode` to 1 mid-burst has no effect.
  - Dropping `en` for one cycle mid-burst stretches `busy` by one cycle.
- Assert `clr`=0 mid-burst → `q_reg`=0000 and `busy`=0 immediately, with no `done`. Then `start`=1 with `mode`=1 and `d`=1001 → plain load gives 1001, with `busy` staying 0.
- `start`=1 with `len`=0 and `mode`=2 → a single ordinary shift, with no `busy` and no `done`.
